// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Provides the sequencer state type, the default operand width and the counter-width helper.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count operand positions 0..n-1; never narrower than one bit.
    function automatic int calcCw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder that the serial sequencer time-shares across operand bits.
module fa (
    output logic Cout,
    output logic Sum,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: feeds one operand bit per cycle, LSB first, through a single full adder.
// Optional macro SERIAL_ADD_SUB_EN adds a Sub input that turns the operation into OpA - OpB.
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] OpA,
    input  logic [N-1:0] OpB,
    input  logic         Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         Sub,
`endif
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    localparam int CW = calcCw(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_shA;
    logic [N-1:0]    r_shB;
    logic [N-1:0]    r_shS;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_sum;
    logic            r_cout;

    logic            w_faSum;
    logic            w_faCout;
    logic [N-1:0]    w_shSNext;

    fa u_fa (w_faCout, w_faSum, r_shA[0], r_shB[0], r_carry);

    // New sum bit enters at the MSB so after N shifts the first bit sits at bit 0.
    assign w_shSNext = {w_faSum, (N-1)'(r_shS >> 1)};

    assign Busy = (r_state == RUN);
    assign Done = (r_state == DONE);
    assign Sum  = r_sum;
    assign Cout = r_cout;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_shA   <= '0;
            r_shB   <= '0;
            r_shS   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_state <= RUN;
                        r_shA   <= OpA;
                        r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        // Two's-complement subtract: invert B and force the carry-in.
                        r_shB   <= Sub ? ~OpB : OpB;
                        r_carry <= Sub ? 1'b1 : Cin;
`else
                        r_shB   <= OpB;
                        r_carry <= Cin;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_shA   <= r_shA >> 1;
                    r_shB   <= r_shB >> 1;
                    r_shS   <= w_shSNext;
                    r_carry <= w_faCout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state <= DONE;
                        r_sum   <= w_shSNext;
                        r_cout  <= w_faCout;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
